// File: rtl/cqf_pkg.sv
// Shared types and constants for the CQF transmit scheduler: FSM state
// encoding, byte width and the elaboration-time parameter legality check.
package cqf_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } cqf_state_e;

  // A guard of at least one clock keeps the wrap clock outside the drain window.
  function automatic bit cqf_params_ok(input int cycle_len, input int guard, input int cnt_w);
    longint span;
    if (cnt_w < 1 || cnt_w > 31) return 1'b0;
    span = longint'(1) << cnt_w;
    return (guard >= 1) && (cycle_len > guard + 4) && (span >= longint'(cycle_len));
  endfunction

endpackage

// File: rtl/cqf_cycle_timer.sv
// CQF cycle timer: free-running cycle counter, drain window, queue-select
// toggle on the wrap clock and a cycle-start pulse on the first clock of a cycle.
module cqf_cycle_timer #(
  parameter int CYCLE_LEN = 1000,
  parameter int GUARD     = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             drain_win_o,
  output logic             fifo_sel_o,
  output logic             cycle_start_o
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CYCLE_LEN - 1);
  localparam logic [CNT_W-1:0] WIN_END = CNT_W'(CYCLE_LEN - GUARD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             start_q, start_d;
  logic             wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    sel_d   = sel_q ^ wrap;
    start_d = wrap;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      start_q <= start_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign wrap_o        = wrap;
  assign drain_win_o   = (cnt_q < WIN_END);
  assign fifo_sel_o    = sel_q;
  assign cycle_start_o = start_q;

endmodule

// File: rtl/cqf_tx_scheduler.sv
// CQF transmit scheduler: drains the queue not being written this cycle into
// the egress MAC byte stream and counts cycles that end with residue left over.
module cqf_tx_scheduler
  import cqf_pkg::*;
#(
  parameter int CYCLE_LEN = 1000,
  parameter int GUARD     = 16,
  parameter int CNT_W     = 16,
  parameter int LATE_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              fifo_sel_o,
  output logic              req_o,
  input  logic              ack_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic [1:0]        status_i,
  input  logic              tx_rdy_i,
  output logic              tx_vld_o,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              tx_end_o,
  output logic              cycle_start_o,
  output logic [LATE_W-1:0] late_cnt_o,
  output cqf_state_e        dbg_state_o,
  output logic [CNT_W-1:0]  dbg_cnt_o
);

  if (!cqf_params_ok(CYCLE_LEN, GUARD, CNT_W)) begin : g_param_check
    $error("cqf_tx_scheduler: illegal CYCLE_LEN/GUARD/CNT_W combination");
  end

  logic             wrap;
  logic             drain_win;
  logic             sel;
  logic [CNT_W-1:0] cnt;

  cqf_cycle_timer #(
    .CYCLE_LEN(CYCLE_LEN),
    .GUARD    (GUARD),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cnt_o        (cnt),
    .wrap_o       (wrap),
    .drain_win_o  (drain_win),
    .fifo_sel_o   (sel),
    .cycle_start_o(cycle_start_o)
  );

  cqf_state_e        state_q, state_d;
  logic              rd_q, rd_d;
  logic              vld_q, vld_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [LATE_W-1:0] late_q, late_d;
  logic              frame_rdy;
  logic              req;
  logic              tx_end;

  // The drained queue is always the one the ingress side is not writing.
  assign frame_rdy = status_i[~sel];
  assign req       = (state_q == ST_DRAIN) && drain_win && tx_rdy_i;

  always_comb begin
    state_d = state_q;
    tx_end  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (drain_win && frame_rdy) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!ack_i) begin
          state_d = ST_DONE;
          tx_end  = 1'b1;
        end else if (!drain_win) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (wrap) state_d = ST_IDLE;
  end

  // Read data arrives one clock after the read; it is registered once more
  // so the byte stream is a clean register output.
  always_comb begin
    rd_d   = req && ack_i;
    vld_d  = rd_q;
    data_d = rd_q ? data_i : data_q;
    late_d = (wrap && ack_i && (late_q != '1)) ? late_q + 1'b1 : late_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      late_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      late_q  <= late_d;
    end
  end

  assign fifo_sel_o  = sel;
  assign req_o       = req;
  assign tx_vld_o    = vld_q;
  assign tx_data_o   = data_q;
  assign tx_end_o    = tx_end;
  assign late_cnt_o  = late_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt;

endmodule

// File: tb/tb_cqf_tx_scheduler.sv
// Bench for cqf_tx_scheduler: a two-queue model answers the read port, a cycle
// model predicts control outputs, and a scoreboard checks the byte stream.
module tb_cqf_tx_scheduler;
  import cqf_pkg::*;

  localparam int CL = 64;
  localparam int GD = 8;
  localparam int CW = 8;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          fifo_sel_o, req_o, ack_i, tx_rdy_i;
  logic          tx_vld_o, tx_end_o, cycle_start_o;
  logic [7:0]    data_i, tx_data_o;
  logic [1:0]    status_i;
  logic [LW-1:0] late_cnt_o;
  cqf_state_e    dbg_state_o;
  logic [CW-1:0] dbg_cnt_o;

  always #5 clk = ~clk;

  cqf_tx_scheduler #(
    .CYCLE_LEN(CL),
    .GUARD    (GD),
    .CNT_W    (CW),
    .LATE_W   (LW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .fifo_sel_o   (fifo_sel_o),
    .req_o        (req_o),
    .ack_i        (ack_i),
    .data_i       (data_i),
    .status_i     (status_i),
    .tx_rdy_i     (tx_rdy_i),
    .tx_vld_o     (tx_vld_o),
    .tx_data_o    (tx_data_o),
    .tx_end_o     (tx_end_o),
    .cycle_start_o(cycle_start_o),
    .late_cnt_o   (late_cnt_o),
    .dbg_state_o  (dbg_state_o),
    .dbg_cnt_o    (dbg_cnt_o)
  );

  // Queue-stage model: ack/status follow the queue lengths combinationally.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         len0 = 0;
  int         len1 = 0;

  assign ack_i    = fifo_sel_o ? (len0 != 0) : (len1 != 0);
  assign status_i = {len1 != 0, len0 != 0};

  logic [7:0] exp_q[$];
  int         lat_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int            m_cnt;
  logic          m_sel, m_cs;
  logic [LW-1:0] m_late;
  cqf_state_e    m_state;

  int   n_reads, n_out, n_end, n_tog, n_cs;
  int   first_vld, last_vld, cur_run, max_run;
  logic saw_done, last_sel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    n_reads = 0; n_out = 0; n_end = 0; n_tog = 0; n_cs = 0;
    first_vld = -1; last_vld = -1; cur_run = 0; max_run = 0;
    saw_done = 1'b0; last_sel = fifo_sel_o;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sel = 1'b0; m_cs = 1'b0; m_late = '0; m_state = ST_IDLE;
    exp_q.delete(); lat_q.delete();
  endtask

  task automatic load(input logic which, input int n, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < n; i++) begin
      if (which) q1.push_back(base + 8'(i) * step);
      else       q0.push_back(base + 8'(i) * step);
    end
    len0 = q0.size();
    len1 = q1.size();
  endtask

  // One clock: check at the falling edge, advance the model, then apply the
  // queue-stage response just after the rising edge.
  task automatic cycle();
    logic       rd_now, rd_sel, m_win, m_wrap, m_frame, exp_req, exp_end;
    logic [7:0] b;
    b = 8'h00;
    @(negedge clk);
    cyc++;
    m_win   = (m_cnt < CL - GD);
    m_wrap  = (m_cnt == CL - 1);
    m_frame = m_sel ? status_i[0] : status_i[1];
    exp_req = (m_state == ST_DRAIN) && m_win && tx_rdy_i;
    exp_end = (m_state == ST_DRAIN) && !ack_i;
    chk("cnt", dbg_cnt_o, m_cnt);
    chk("sel", fifo_sel_o, m_sel);
    chk("cycle_start", cycle_start_o, m_cs);
    chk("late", late_cnt_o, m_late);
    chk("state", dbg_state_o, m_state);
    chk("req", req_o, exp_req);
    chk("tx_end", tx_end_o, exp_end);
    while (lat_q.size() > 0 && lat_q[0] < cyc) begin
      chk("tx_due", cyc, lat_q.pop_front());
      void'(exp_q.pop_front());
    end
    if (tx_vld_o === 1'b1) begin
      n_out++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
      if (exp_q.size() == 0) chk("vld_extra", tx_vld_o, 1'b0);
      else begin
        chk("tx_data", tx_data_o, exp_q.pop_front());
        chk("tx_lat", cyc, lat_q.pop_front());
      end
    end else begin
      cur_run = 0;
    end
    if (tx_end_o === 1'b1) n_end++;
    if (cycle_start_o === 1'b1) n_cs++;
    if (fifo_sel_o !== last_sel) n_tog++;
    last_sel = fifo_sel_o;
    if (dbg_state_o == ST_DONE) saw_done = 1'b1;
    rd_now = req_o && ack_i;
    rd_sel = fifo_sel_o;
    if (rd_now) begin
      n_reads++;
      b = rd_sel ? q0.pop_front() : q1.pop_front();
      exp_q.push_back(b);
      lat_q.push_back(cyc + 2);
    end
    if (m_wrap && ack_i && (m_late != '1)) m_late = m_late + 1'b1;
    case (m_state)
      ST_IDLE:  if (m_win && m_frame) m_state = ST_DRAIN;
      ST_DRAIN: if (!ack_i) m_state = ST_DONE; else if (!m_win) m_state = ST_IDLE;
      default:  m_state = m_state;
    endcase
    if (m_wrap) m_state = ST_IDLE;
    m_cs  = m_wrap;
    m_sel = m_sel ^ m_wrap;
    m_cnt = m_wrap ? 0 : m_cnt + 1;
    @(posedge clk);
    #1;
    if (rd_now) data_i = b;
    len0 = q0.size();
    len1 = q1.size();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_cnt(input int k);
    int budget;
    budget = 0;
    while (m_cnt != k && budget < 4 * CL) begin
      cycle();
      budget++;
    end
    chk("sync_cnt", m_cnt, k);
  endtask

  task automatic wait_reads(input int k);
    int budget;
    budget = 0;
    while (n_reads < k && budget < 2 * CL) begin
      cycle();
      budget++;
    end
    chk("reads_reach", n_reads, k);
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    chk({tag, "_vld"}, tx_vld_o, 1'b0);
    chk({tag, "_req"}, req_o, 1'b0);
    chk({tag, "_sel"}, fifo_sel_o, 1'b0);
    chk({tag, "_cnt"}, dbg_cnt_o, 0);
    chk({tag, "_late"}, late_cnt_o, 0);
    chk({tag, "_cs"}, cycle_start_o, 1'b0);
    chk({tag, "_end"}, tx_end_o, 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    q0.delete(); q1.delete();
    len0 = 0; len1 = 0;
    data_i = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sel0;
    rst_i    = 1'b1;
    tx_rdy_i = 1'b1;
    data_i   = 8'h00;
    model_reset();
    do_reset("rst");

    // Idle: only the timer moves.
    clear_stats();
    run(130);
    chk("idle_toggles", n_tog, 2);
    chk("idle_starts", n_cs, 2);
    chk("idle_reads", n_reads, 0);
    chk("idle_late", late_cnt_o, 0);

    // Ten bytes in the drained queue, MAC always ready.
    clear_stats();
    load(!m_sel, 10, 8'h01, 8'h01);
    run(20);
    chk("rd10_reads", n_reads, 10);
    chk("rd10_out", n_out, 10);
    chk("rd10_end", n_end, 1);
    chk("rd10_run", max_run, 10);
    chk("rd10_gap", last_vld - first_vld + 1 - n_out, 0);
    chk("rd10_done", saw_done, 1'b1);
    chk("rd10_sb", exp_q.size(), 0);

    // Backpressure for three clocks after the fourth read.
    run_until_cnt(0);
    clear_stats();
    load(!m_sel, 10, 8'h40, 8'h01);
    wait_reads(4);
    tx_rdy_i = 1'b0;
    run(3);
    tx_rdy_i = 1'b1;
    run(20);
    chk("bp_reads", n_reads, 10);
    chk("bp_out", n_out, 10);
    chk("bp_gap", last_vld - first_vld + 1 - n_out, 3);
    chk("bp_run", max_run, 6);
    chk("bp_sb", exp_q.size(), 0);

    // Overrun: 100 bytes cannot drain before the guard interval.
    run_until_cnt(0);
    clear_stats();
    sel0 = m_sel;
    load(!m_sel, 100, 8'h01, 8'h03);
    run_until_cnt(60);
    chk("ovr_reads", n_reads, CL - GD - 1);
    chk("ovr_late_pre", late_cnt_o, 0);
    run_until_cnt(1);
    chk("ovr_late", late_cnt_o, 1);
    chk("ovr_sel", fifo_sel_o, !sel0);
    chk("ovr_out", n_out, CL - GD - 1);
    chk("ovr_resid", sel0 ? len0 : len1, 100 - (CL - GD - 1));
    chk("ovr_sb", exp_q.size(), 0);

    // Keep both queues overfull so every wrap is late; the counter saturates.
    load(1'b0, 200, 8'h80, 8'h01);
    load(1'b1, 200, 8'hC0, 8'h01);
    for (int k = 1; k <= 4; k++) begin
      run_until_cnt(CL - 1);
      run(2);
      chk($sformatf("sat_late%0d", k), late_cnt_o, (k >= 2) ? 3 : 1 + k);
    end

    // Reset in the middle of a drain discards in-flight bytes.
    run_until_cnt(0);
    clear_stats();
    wait_reads(5);
    do_reset("rst_mid");
    clear_stats();
    run(10);
    chk("post_rst_out", n_out, 0);
    chk("post_rst_reads", n_reads, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cqf_tx_scheduler.md
Name: cqf_tx_scheduler

Overview:
- Downstream consumer of the two-queue CQF queue-management stage.
- Owns the CQF cycle timer and drives the queue-select line: the ingress side writes one queue while this block drains the other.
- Pulls bytes through the queue's req/ack read port and presents them to the egress MAC as a valid/data byte stream.
- Stops issuing reads a guard interval before each cycle boundary and counts cycles that end with residue still in the drained queue.

Parameters:
- CYCLE_LEN, 1000: clocks per CQF cycle; must be greater than GUARD+4.
- GUARD, 16: clocks at the end of each cycle during which no new read is issued.
- CNT_W, 16: width of the cycle counter; must satisfy 2^CNT_W >= CYCLE_LEN.
- LATE_W, 16: width of the late-cycle counter.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous reset, active-high.
- fifo_sel_o  out  1  queue select to the queue stage. 0 means ingress writes queue0 and this block drains queue1.
- req_o  out  1  read request to the queue stage.
- ack_i  in  1  the drained queue is non-empty (combinational from the queue stage).
- data_i  in  8  queue read data, valid one clock after a read.
- status_i  in  2  per-queue "complete frame present" flags.
- tx_rdy_i  in  1  MAC can accept new reads.
- tx_vld_o  out  1  output byte valid.
- tx_data_o  out  8  output byte.
- tx_end_o  out  1  one-clock pulse when the drained queue empties during DRAIN.
- cycle_start_o  out  1  one-clock pulse on the first clock of each cycle.
- late_cnt_o  out  LATE_W  number of cycles that ended with the drained queue non-empty.

Behaviour:
- Reset values: all outputs 0, cnt=0, state=IDLE, fifo_sel_o=0, in-flight pipeline flags cleared. Reset applied mid-drain discards in-flight bytes, and tx_vld_o is 0 on the next clock.
- Cycle counter: cnt increments every clock and wraps from CYCLE_LEN-1 to 0.
  - On the wrap clock, fifo_sel_o toggles (registered) and cycle_start_o pulses one clock later, i.e. when cnt=0.
- drain_win = (cnt < CYCLE_LEN-GUARD).
- Drained queue index q = ~fifo_sel_o.
- FSM states: IDLE, DRAIN, DONE.
  - IDLE -> DRAIN when drain_win & status_i[q].
  - DRAIN -> DONE when ack_i=0; pulse tx_end_o on this clock.
  - DRAIN -> IDLE when drain_win goes low (guard reached).
  - DONE -> IDLE on the wrap clock.
  - Any state -> IDLE on the wrap clock, taking priority over all other transitions.
- Read request: req_o = (state==DRAIN) & drain_win & tx_rdy_i, combinational. A read occurs when req_o & ack_i.
- Read pipeline:
  - rd_d is registered from (req_o & ack_i).
  - When rd_d=1, data_i is captured into tx_data_o and tx_vld_o=1 on the following clock.
  - Latency from read clock to tx_vld_o is 2 clocks.
- Backpressure: tx_rdy_i low stops new reads at once. Up to 2 already-issued bytes are still delivered, and the MAC must accept them.
- Late count: on the wrap clock, if ack_i=1, late_cnt_o increments, saturating at all-ones. Residue stays in the queue and is drained normally in a later cycle when that queue is selected again.
- Simultaneous events:
  - Wrap clock coinciding with ack_i falling: late is not counted (ack_i=0) and tx_end_o still pulses.
  - In-flight bytes across the wrap still emerge on tx_vld_o after the toggle, because they were already read.
- No read is issued on the wrap clock itself, because drain_win is 0 there.

Decomposition:
- Package cqf_pkg: state enum (IDLE/DRAIN/DONE), byte width constant 8, and the parameter-legality check as a function.
- One natural sub-module, cqf_cycle_timer, holding cnt, wrap, drain_win, the fifo_sel_o toggle and cycle_start_o. The FSM and read pipeline stay in the top.

Test Plan (all with CYCLE_LEN=64, GUARD=8):
- Reset then idle, status_i=0 -> fifo_sel_o toggles at clocks 64, 128, ...; cycle_start_o pulses at 65, 129; req_o stays 0; late_cnt_o=0.
- Queue1 holds 10 bytes 0x01..0x0A, status_i[1]=1, sel=0, tx_rdy_i=1:
  - 10 reads; tx_vld_o high for 10 consecutive clocks, 2 clocks after the first read, with bytes in order.
  - tx_end_o pulses once; state reaches DONE.
- Same setup with tx_rdy_i low for 3 clocks after the 4th read -> exactly 2 further bytes are delivered, then a 3-clock gap, then the remaining bytes. No byte is lost or duplicated.
- Queue holds 100 bytes -> reads stop at cnt=56; at the wrap ack_i=1, so late_cnt_o=1; fifo_sel_o toggles; the in-flight bytes are still output.
- rst_i asserted mid-drain at byte 5 -> next clock tx_vld_o=0, req_o=0, fifo_sel_o=0, cnt=0.
- late_cnt_o preset near all-ones via repeated overrun (LATE_W=2) -> the count stays at 3 after the 4th late cycle.
